// File: rtl/multiplier_acc_pipe.sv
// multiplier_acc_pipe
// Pipelined multiply / multiply-accumulate unit.
//   Each accepted operand pair is multiplied at full 2*BITWIDTH precision.
//   The product is sign- or zero-extended to ACCWIDTH. It then either loads
//   the result register or is added to it (wrapping), after STAGES edges.
//
// Parameters
//   BITWIDTH  operand width
//   STAGES    total pipeline depth including the result stage (>=1)
//   ACCWIDTH  result / accumulator width (>=2*BITWIDTH)
//
// Ports
//   iClk     clock, rising edge
//   iRst     synchronous active-high reset (highest priority)
//   iEn      pipeline advance enable; low freezes all state
//   iClr     synchronous accumulator clear + pipeline flush (beats iEn)
//   iValid   operands present this cycle
//   iSigned  1 = two's-complement operands, 0 = unsigned
//   iAcc     1 = accumulate product, 0 = load product
//   iData0   operand A
//   iData1   operand B
//   oValid   one-cycle strobe following each result update
//   oData    result / accumulator register
//   oOvf     sticky accumulate-overflow flag
module multiplier_acc_pipe #(
  parameter int BITWIDTH = 32,
  parameter int STAGES   = 2,
  parameter int ACCWIDTH = 2*BITWIDTH+8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iValid,
  input  logic                iSigned,
  input  logic                iAcc,
  input  logic [BITWIDTH-1:0] iData0,
  input  logic [BITWIDTH-1:0] iData1,
  output logic                oValid,
  output logic [ACCWIDTH-1:0] oData,
  output logic                oOvf
);

  localparam int PW = 2*BITWIDTH;

  // Full-precision product, extended to the accumulator width.
  function automatic logic [ACCWIDTH-1:0] extendProd(
    input logic [BITWIDTH-1:0] a,
    input logic [BITWIDTH-1:0] b,
    input logic                sgn
  );
    logic signed [PW-1:0] sp;
    logic        [PW-1:0] up;
    logic        [ACCWIDTH-1:0] ext;
    if (sgn) begin
      sp  = $signed({{BITWIDTH{a[BITWIDTH-1]}}, a}) *
            $signed({{BITWIDTH{b[BITWIDTH-1]}}, b});
      ext = ACCWIDTH'(sp);
    end else begin
      up  = {{BITWIDTH{1'b0}}, a} * {{BITWIDTH{1'b0}}, b};
      ext = ACCWIDTH'(up);
    end
    return ext;
  endfunction

  // Overflow of acc + prod: carry-out when unsigned, sign overflow when signed.
  function automatic logic addOvf(
    input logic [ACCWIDTH-1:0] a,
    input logic [ACCWIDTH-1:0] b,
    input logic                sgn
  );
    logic [ACCWIDTH:0] full;
    full = {1'b0, a} + {1'b0, b};
    if (sgn)
      return (a[ACCWIDTH-1] == b[ACCWIDTH-1]) && (full[ACCWIDTH-1] != a[ACCWIDTH-1]);
    else
      return full[ACCWIDTH];
  endfunction

  logic                accept;
  logic                finVld;
  logic                finSgn;
  logic                finAcc;
  logic [ACCWIDTH-1:0] finProd;
  logic [ACCWIDTH-1:0] accSum;

  assign accept = iValid & iEn & ~iClr & ~iRst;

  generate
    if (STAGES == 1) begin : gDirect
      // Single-stage: the accepting edge is also the result edge.
      assign finVld  = accept;
      assign finProd = extendProd(iData0, iData1, iSigned);
      assign finSgn  = iSigned;
      assign finAcc  = iAcc;
    end else begin : gPipe
      logic [ACCWIDTH-1:0] prodPipe [STAGES-1];
      logic [STAGES-2:0]   vldPipe;
      logic [STAGES-2:0]   sgnPipe;
      logic [STAGES-2:0]   accPipe;

      // Operand stages: valid bits are the only control state here.
      always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
          vldPipe <= '0;
        end else if (iEn) begin
          vldPipe[0] <= accept;
          for (int i = 1; i < STAGES-1; i++) vldPipe[i] <= vldPipe[i-1];
        end
      end

      always_ff @(posedge iClk) begin
        if (iEn) begin
          prodPipe[0] <= extendProd(iData0, iData1, iSigned);
          sgnPipe[0]  <= iSigned;
          accPipe[0]  <= iAcc;
          for (int i = 1; i < STAGES-1; i++) begin
            prodPipe[i] <= prodPipe[i-1];
            sgnPipe[i]  <= sgnPipe[i-1];
            accPipe[i]  <= accPipe[i-1];
          end
        end
      end

      assign finVld  = vldPipe[STAGES-2];
      assign finProd = prodPipe[STAGES-2];
      assign finSgn  = sgnPipe[STAGES-2];
      assign finAcc  = accPipe[STAGES-2];
    end
  endgenerate

  assign accSum = oData + finProd;

  // Result stage
  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      oData  <= '0;
      oValid <= 1'b0;
      oOvf   <= 1'b0;
    end else if (iEn) begin
      oValid <= finVld;
      if (finVld) begin
        if (finAcc) begin
          oData <= accSum;
          oOvf  <= oOvf | addOvf(oData, finProd, finSgn);
        end else begin
          oData <= finProd;
        end
      end
    end else begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplier_acc_pipe.sv
module tb_multiplier_acc_pipe;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEn = 1'b0;
  logic        iClr = 1'b0;
  logic        iValid = 1'b0;
  logic        iSigned = 1'b0;
  logic        iAcc = 1'b0;
  logic [7:0]  iData0 = '0;
  logic [7:0]  iData1 = '0;
  logic        oValid;
  logic [23:0] oData;
  logic        oOvf;

  multiplier_acc_pipe #(.BITWIDTH(8), .STAGES(2), .ACCWIDTH(24)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iValid(iValid),
    .iSigned(iSigned), .iAcc(iAcc), .iData0(iData0), .iData1(iData1),
    .oValid(oValid), .oData(oData), .oOvf(oOvf)
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad = 0;

  // Reference model state: the value the result register should hold.
  logic [23:0] mAcc = '0;
  logic        mOvf = 1'b0;
  logic [24:0] expQ [$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic modelPush(input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic ac);
    longint sa, sb, p, us, ss;
    logic [23:0] ext;
    sa  = s ? longint'($signed(a)) : longint'(a);
    sb  = s ? longint'($signed(b)) : longint'(b);
    p   = sa * sb;
    ext = p[23:0];
    if (!ac) begin
      mAcc = ext;
    end else begin
      us = longint'(mAcc) + longint'(ext);
      if (s) begin
        ss = longint'($signed(mAcc)) + longint'($signed(ext));
        if (ss > 8388607 || ss < -8388608) mOvf = 1'b1;
      end else if (us >= 64'd16777216) begin
        mOvf = 1'b1;
      end
      mAcc = us[23:0];
    end
    expQ.push_back({mOvf, mAcc});
  endtask

  // Apply one cycle of inputs; the model observes the same edge the DUT does.
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic ac, input logic v, input logic en, input logic clr);
    iData0 = a; iData1 = b; iSigned = s; iAcc = ac;
    iValid = v; iEn = en; iClr = clr;
    @(posedge iClk);
    if (!iRst) begin
      if (clr) begin
        mAcc = '0; mOvf = 1'b0;
      end else if (v && en) begin
        modelPush(a, b, s, ac);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: every result strobe must match the next expected result.
  always @(negedge iClk) begin
    if (oValid) begin
      if (expQ.size() == 0) begin
        check("unexpected_oValid", 1, 0);
      end else begin
        logic [24:0] e;
        e = expQ.pop_front();
        check("oData", oData, e[23:0]);
        check("oOvf", oOvf, e[24]);
      end
    end
  end

  initial begin
    // Reset with random inputs
    iRst = 1'b1;
    for (int i = 0; i < 2; i++)
      beat(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'($urandom));
    check("rst_oData", oData, 0);
    check("rst_oValid", oValid, 0);
    check("rst_oOvf", oOvf, 0);
    iRst = 1'b0;
    idle(1);
    check("idle_oValid", oValid, 0);

    // Unsigned multiply, latency and hold
    beat(8'd10, 8'd20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("lat_edge1_oValid", oValid, 0);
    idle(1);
    check("lat_edge2_oValid", oValid, 1);
    check("umul_oData", oData, 200);
    idle(1);
    check("strobe_one_cycle", oValid, 0);
    idle(2);
    check("hold_oData", oData, 200);

    // Signed multiply
    beat(8'hFD, 8'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("smul_oData", oData, 24'hFFFFF1);

    // Accumulate 4 back-to-back
    beat(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) beat(8'd10, 8'd20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("acc_b2b_oValid", oValid, 1);
    check("acc_b2b_oData", oData, 600);
    idle(1);
    check("acc_b2b_final", oData, 800);
    idle(2);

    // Stall mid-stream
    beat(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(8'd3, 8'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    beat(8'd4, 8'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      beat(8'd99, 8'd99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("stall_oValid", oValid, 0);
    end
    beat(8'd6, 8'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("stall_total", oData, 21 + 20 + 12);

    // Clear with iValid=1: input dropped
    beat(8'd9, 8'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_oData", oData, 0);
    idle(3);
    check("clr_dropped_oData", oData, 0);

    // Randomized traffic, cleared only when drained
    for (int blk = 0; blk < 4; blk++) begin
      beat(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 60; i++)
        beat(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
             1'($urandom), ($urandom_range(0, 4) != 0), 1'b0);
      idle(4);
    end

    // Unsigned overflow
    beat(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 259; i++) beat(8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("ovf_oData", oData, 64259);
    check("ovf_oOvf", oOvf, 1);
    beat(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovf_clr_oOvf", oOvf, 0);
    check("ovf_clr_oData", oData, 0);

    idle(2);
    check("all_results_seen", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplier_acc_pipe.md
MULTIPLIER_ACC_PIPE -- requirements
Module: multiplier_acc_pipe

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32: operand width.
REQ-002 SHALL have parameter STAGES, default 2, legal range >=1: total pipeline depth, including the result stage.
REQ-003 SHALL have parameter ACCWIDTH, default 2*BITWIDTH+8, legal range >=2*BITWIDTH: result/accumulator width.
REQ-004 SHALL have port iClk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port iRst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port iEn, input, 1 bit: pipeline advance enable; low freezes all state.
REQ-007 SHALL have port iClr, input, 1 bit: synchronous accumulator clear and pipeline flush.
REQ-008 SHALL have port iValid, input, 1 bit: operands present this cycle.
REQ-009 SHALL have port iSigned, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port iAcc, input, 1 bit: 1 = accumulate product, 0 = load product.
REQ-011 SHALL have ports iData0 and iData1, input, BITWIDTH bits each: operands.
REQ-012 SHALL have port oValid, input-to-output direction output, 1 bit: one-cycle result strobe.
REQ-013 SHALL have port oData, output, ACCWIDTH bits: result/accumulator register.
REQ-014 SHALL have port oOvf, output, 1 bit: sticky accumulate-overflow flag.

Function
REQ-015 SHALL accept an input at a rising edge when iValid=1, iEn=1, iClr=0 and iRst=0; an input is dropped in any other case.
REQ-016 SHALL capture iSigned and iAcc with the operands and carry them through the pipeline alongside the data.
REQ-017 SHALL form the product as the full 2*BITWIDTH-bit result, sign-extended to ACCWIDTH when signed and zero-extended when unsigned.
REQ-018 SHALL update oData at the STAGES-th rising edge counting the accepting edge as the first; with STAGES=1 it updates at the accepting edge.
REQ-019 SHALL, at the final stage, load oData with the extended product when iAcc=0 and with oData plus the extended product when iAcc=1.
REQ-020 SHALL wrap accumulation modulo 2^ACCWIDTH.
REQ-021 SHALL set oOvf in accumulate mode only, on carry-out of bit ACCWIDTH-1 when unsigned or on signed-add overflow when signed; oOvf stays set until iClr or iRst.
REQ-022 SHALL assert oValid for exactly the one cycle following each edge at which oData is updated, and hold it at 0 at all other times.
REQ-023 SHALL accept back-to-back inputs at one per cycle, producing oValid on consecutive cycles.
REQ-024 SHALL, while iEn=0, hold every pipeline register, oData and oOvf, drive oValid to 0 from the next cycle, and lose no in-flight data.
REQ-025 SHALL, on iClr=1, clear oData, oOvf, oValid and all in-flight valid bits at that edge regardless of iEn.
REQ-026 SHALL give iRst priority over iClr, and iClr priority over iEn.
REQ-027 SHALL hold oData between results.
REQ-028 SHALL start an accumulation on the first iAcc=1 item after iClr from 0.

Reset
REQ-029 SHALL, at any rising edge with iRst=1 (including mid-stream), set oData=0, oValid=0 and oOvf=0, and clear all pipeline valid bits, discarding in-flight items.
REQ-030 SHALL clear only the valid bits and result registers on reset; operand pipeline data registers need no reset.

Verification (BITWIDTH=8, STAGES=2, ACCWIDTH=24)
REQ-031 SHALL cover reset: iRst=1 for 2 cycles with random inputs -> oData=0, oValid=0, oOvf=0; no oValid until 2 edges after the first accepted input.
REQ-032 SHALL cover unsigned multiply: iData0=10, iData1=20, iAcc=0, iSigned=0, one beat -> oValid pulses once 2 edges later, oData=200, oOvf=0.
REQ-033 SHALL cover signed multiply: iData0=0xFD (-3), iData1=5, iSigned=1, iAcc=0 -> oData=0xFFFFF1 (-15).
REQ-034 SHALL cover accumulate: iClr pulse, then 4 back-to-back beats of 10*20 with iAcc=1 -> oValid on 4 consecutive cycles, oData=200, 400, 600, 800.
REQ-035 SHALL cover stall and clear: drop iEn for 3 cycles mid-stream -> no oValid during the stall and the correct total after resume; iClr asserted with iValid=1 -> input dropped, oData=0.
REQ-036 SHALL cover overflow: iClr, then 259 beats of 255*255 unsigned with iAcc=1 -> final oData=64259, oOvf=1; a following iClr -> oOvf=0.
